// File: rtl/vscale_dmem_responder.sv
`default_nettype none
// ============================================================================
// Module : vscale_dmem_responder
// Desc   : Data-memory responder for the vscale dmem port: word SRAM with byte
//          lanes, range/alignment error reporting and programmable wait states.
// Rev    : 1.0 - initial release
// ============================================================================
module vscale_dmem_responder #(
  parameter int unsigned ADDR_BITS   = 10,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned WAIT_CYCLES = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        dmem_en,
  input  logic        dmem_wen,
  input  logic [2:0]  dmem_size,
  input  logic [31:0] dmem_addr,
  input  logic [31:0] dmem_wdata_delayed,
  output logic [31:0] dmem_rdata,
  output logic        dmem_wait,
  output logic        dmem_badmem_e
);

  localparam logic [1:0]  c_st_idle   = 2'd0;
  localparam logic [1:0]  c_st_wait   = 2'd1;
  localparam logic [1:0]  c_st_resp   = 2'd2;
  localparam logic [2:0]  c_sz_b      = 3'd0;
  localparam logic [2:0]  c_sz_h      = 3'd1;
  localparam logic [2:0]  c_sz_w      = 3'd2;
  localparam int unsigned c_words     = 1 << ADDR_BITS;
  // Span kept 33 bits wide so the limit itself never wraps.
  localparam logic [32:0] c_span      = 33'(c_words) << 2;
  localparam logic [3:0]  c_wait_init = 4'(WAIT_CYCLES);

  logic [1:0]           state_q, state_d;
  logic [3:0]           cnt_q, cnt_d;
  logic                 wen_q;
  logic [2:0]           size_q;
  logic [1:0]           lane_q;
  logic [ADDR_BITS-1:0] idx_q;
  logic                 bad_q;
  logic [31:0]          mem_q [c_words];

  logic                 w_accept;
  logic [31:0]          w_off;
  logic                 w_out_of_range;
  logic                 w_misaligned;
  logic                 w_bad;
  logic [3:0]           w_be;
  logic                 w_resp;
  logic                 w_write;

  assign w_accept       = dmem_en & ~dmem_wait;
  assign w_off          = dmem_addr - BASE_ADDR;
  assign w_out_of_range = {1'b0, w_off} >= c_span;
  assign w_misaligned   = ((dmem_size == c_sz_h) & dmem_addr[0]) |
                          ((dmem_size == c_sz_w) & (dmem_addr[1:0] != 2'b00));
  assign w_bad          = w_out_of_range | w_misaligned;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      c_st_idle, c_st_resp: begin
        if (w_accept) begin
          if (WAIT_CYCLES > 0) begin
            state_d = c_st_wait;
            cnt_d   = c_wait_init;
          end else begin
            state_d = c_st_resp;
          end
        end else begin
          state_d = c_st_idle;
        end
      end
      c_st_wait: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) begin
          state_d = c_st_resp;
        end
      end
      default: state_d = c_st_idle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= c_st_idle;
      cnt_q   <= 4'd0;
      wen_q   <= 1'b0;
      size_q  <= 3'd0;
      lane_q  <= 2'd0;
      idx_q   <= '0;
      bad_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (w_accept) begin
        wen_q  <= dmem_wen;
        size_q <= dmem_size;
        lane_q <= dmem_addr[1:0];
        idx_q  <= w_off[ADDR_BITS+1:2];
        bad_q  <= w_bad;
      end
    end
  end

  always_comb begin
    w_be = 4'b1111;
    case (size_q)
      c_sz_b:  w_be = 4'b0001 << lane_q;
      c_sz_h:  w_be = 4'b0011 << {lane_q[1], 1'b0};
      default: w_be = 4'b1111;
    endcase
  end

  assign w_resp  = (state_q == c_st_resp);
  // Reset forces IDLE asynchronously, so an in-flight store never commits.
  assign w_write = w_resp & wen_q & ~bad_q;

  always_ff @(posedge clk) begin
    if (w_write) begin
      for (int b = 0; b < 4; b++) begin
        if (w_be[b]) begin
          mem_q[idx_q][8*b +: 8] <= dmem_wdata_delayed[8*b +: 8];
        end
      end
    end
  end

  assign dmem_wait     = (state_q == c_st_wait);
  assign dmem_badmem_e = bad_q & (state_q != c_st_idle);
  assign dmem_rdata    = (w_resp & ~bad_q) ? mem_q[idx_q] : 32'h0000_0000;

endmodule
`default_nettype wire
